// File: rtl/uart_cmd_sequencer_if.sv
// Signal bundle between the command source / UART_tx and uart_cmd_sequencer.
// master = command source side, slave = the sequencer itself.
interface uart_cmd_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              start;
    logic              abort;
    logic              clr_err;
    logic              tx_done;
    logic [DATA_W-1:0] tx_data;
    logic              trmt;
    logic              busy;
    logic              seq_done;
    logic              timeout_err;
    logic              ovf_err;
    logic [CntW-1:0]   count;
    logic              full;
    logic              empty;

    modport master (
        output push, push_data, start, abort, clr_err, tx_done,
        input  tx_data, trmt, busy, seq_done, timeout_err, ovf_err, count, full, empty
    );

    modport slave (
        input  push, push_data, start, abort, clr_err, tx_done,
        output tx_data, trmt, busy, seq_done, timeout_err, ovf_err, count, full, empty
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Buffers command bytes in a FIFO and feeds them one at a time to a UART
// transmitter, with an inter-byte gap, a per-byte watchdog and an abort.
module uart_cmd_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TMO_W   = 24,
    parameter int unsigned TMO_CYC = 10_000_000,
    parameter int unsigned GAP_CYC = 50
) (
    input logic                 clk,
    input logic                 rst,
    uart_cmd_sequencer_if.slave bus_io
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO_CYC - 1);
    localparam logic [GapW-1:0]  GapLast = GapW'(GAP_CYC);

    typedef enum logic [1:0] {StIdle, StLoad, StWaitDone, StGap} state_e;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   wd_q, wd_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [PtrW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               seq_done_q, seq_done_d;
    logic               tmo_err_q, tmo_err_d;
    logic               ovf_err_q, ovf_err_d;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic pop, flush, tmo_set, done_set, next_byte, push_ok, ovf_set, full, empty;

    assign full  = (cnt_q == CntW'(DEPTH));
    assign empty = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        pop       = 1'b0;
        flush     = 1'b0;
        tmo_set   = 1'b0;
        done_set  = 1'b0;
        next_byte = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start && !empty) state_d = StLoad;
            end
            StLoad: begin
                pop     = 1'b1;
                wd_d    = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                // tx_done beats a watchdog expiry in the same cycle
                if (bus_io.tx_done) begin
                    if (GAP_CYC == 0) begin
                        next_byte = 1'b1;
                    end else begin
                        state_d = StGap;
                        gap_d   = '0;
                    end
                end else if (wd_q == TmoLast) begin
                    tmo_set = 1'b1;
                    flush   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) next_byte = 1'b1;
                else                  gap_d = gap_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (next_byte) begin
            if (!empty) begin
                state_d = StLoad;
            end else begin
                state_d  = StIdle;
                done_set = 1'b1;
            end
        end

        if (bus_io.abort) begin
            state_d  = StIdle;
            pop      = 1'b0;
            flush    = 1'b1;
            tmo_set  = 1'b0;
            done_set = 1'b0;
        end
    end

    always_comb begin
        push_ok   = bus_io.push && (!full || pop) && !flush;
        ovf_set   = bus_io.push && full && !pop && !flush;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop)     rptr_d = rptr_q + 1'b1;
            cnt_d = cnt_q + CntW'(push_ok) - CntW'(pop);
        end
        if (pop) tx_data_d = mem[rptr_q];
        seq_done_d = done_set;
        tmo_err_d  = (tmo_err_q && !bus_io.clr_err) || tmo_set;
        ovf_err_d  = (ovf_err_q && !bus_io.clr_err) || ovf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wd_q       <= '0;
            gap_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            seq_done_q <= 1'b0;
            tmo_err_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            gap_q      <= gap_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            seq_done_q <= seq_done_d;
            tmo_err_q  <= tmo_err_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem[wptr_q] <= bus_io.push_data;
    end

    // Head byte is shown combinationally during LOAD so it is valid with trmt.
    assign bus_io.tx_data     = (state_q == StLoad) ? mem[rptr_q] : tx_data_q;
    assign bus_io.trmt        = (state_q == StLoad) && !bus_io.abort;
    assign bus_io.busy        = (state_q != StIdle);
    assign bus_io.seq_done    = seq_done_q;
    assign bus_io.timeout_err = tmo_err_q;
    assign bus_io.ovf_err     = ovf_err_q;
    assign bus_io.count       = cnt_q;
    assign bus_io.full        = full;
    assign bus_io.empty       = empty;
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: directed scenarios plus randomized
// sequences against a queue-based model with a behavioural UART responder.
module tb_uart_cmd_sequencer;
    localparam int unsigned DataW  = 8;
    localparam int unsigned Depth  = 8;
    localparam int unsigned TmoCyc = 1000;
    localparam int unsigned GapCyc = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_sequencer_if #(.DATA_W(DataW), .DEPTH(Depth)) bus ();

    uart_cmd_sequencer #(
        .DATA_W (DataW),
        .DEPTH  (Depth),
        .TMO_W  (24),
        .TMO_CYC(TmoCyc),
        .GAP_CYC(GapCyc)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    int         trmt_cnt = 0;
    int         done_cnt = 0;
    int         last_trmt_cyc = -100000;
    int         last_done_cyc = 0;
    int         cur_delay = 100;
    bit         done_valid = 1'b0;
    bit         resp_en = 1'b1;
    bit         rand_delay = 1'b0;
    int         fix_delay = 100;
    int         mdl_cnt = 0;
    bit         mdl_ovf = 1'b0;

    task automatic check(input string name, input longint got, input longint expv);
        n_chk++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    endtask

    // Monitor: scoreboard pop on every trmt, gap timing, seq_done pulses.
    initial forever begin
        @(negedge clk);
        if (bus.trmt) begin
            trmt_cnt++;
            if (exp_q.size() == 0) check("trmt_unexpected", bus.trmt, 0);
            else check("tx_data", bus.tx_data, exp_q.pop_front());
            if (done_valid) check("gap_latency", cyc - last_done_cyc, GapCyc + 2);
            done_valid    = 1'b0;
            last_trmt_cyc = cyc;
            cur_delay     = rand_delay ? int'($urandom_range(1, 60)) : fix_delay;
        end
        if (bus.tx_done && bus.busy) begin
            last_done_cyc = cyc;
            done_valid    = 1'b1;
        end
        if (!bus.busy) done_valid = 1'b0;
        if (bus.seq_done) done_cnt++;
    end

    // UART_tx stand-in: tx_done exactly cur_delay cycles after each trmt.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_done = resp_en && (cyc == last_trmt_cyc + cur_delay);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.push      = 1'b1;
        bus.push_data = b;
        tick();
        bus.push = 1'b0;
        if (mdl_cnt < Depth) begin
            exp_q.push_back(b);
            mdl_cnt++;
        end else begin
            mdl_ovf = 1'b1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        mdl_ovf = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 4000) begin
            tick();
            n++;
        end
        check(name, bus.busy, 0);
        tick();
        mdl_cnt = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_trmt"}, bus.trmt, 0);
        check({tag, "_seq_done"}, bus.seq_done, 0);
        check({tag, "_timeout_err"}, bus.timeout_err, 0);
        check({tag, "_ovf_err"}, bus.ovf_err, 0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_empty"}, bus.empty, 1);
        check({tag, "_tx_data"}, bus.tx_data, 0);
    endtask

    initial begin
        int t0, d0, t_start, k, n;
        logic [7:0] b;
        bus.push = 1'b0; bus.push_data = '0; bus.start = 1'b0;
        bus.abort = 1'b0; bus.clr_err = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // start with an empty FIFO is ignored
        pulse_start();
        check("empty_start_busy", bus.busy, 0);
        tick();
        check("empty_start_seq_done", done_cnt, 0);

        // 1: two bytes, 100-cycle UART
        t0 = trmt_cnt; d0 = done_cnt;
        push_byte(8'h47);
        push_byte(8'h53);
        check("t1_count", bus.count, 2);
        pulse_start();
        check("t1_trmt_latency", bus.trmt, 1);
        wait_idle("t1_idle");
        check("t1_trmts", trmt_cnt - t0, 2);
        check("t1_seq_done", done_cnt - d0, 1);
        check("t1_count_end", bus.count, 0);
        check("t1_tmo", bus.timeout_err, 0);
        check("t1_ovf", bus.ovf_err, 0);

        // 2: overflow, clr_err racing a new overflow, then drain
        t0 = trmt_cnt; d0 = done_cnt;
        for (int i = 0; i <= Depth; i++) push_byte(8'($urandom));
        check("t2_full", bus.full, 1);
        check("t2_count", bus.count, Depth);
        check("t2_ovf", bus.ovf_err, mdl_ovf);
        bus.clr_err = 1'b1;
        push_byte(8'($urandom));
        bus.clr_err = 1'b0;
        check("t2_clr_vs_new_ovf", bus.ovf_err, 1);
        pulse_clr();
        check("t2_ovf_cleared", bus.ovf_err, 0);
        pulse_start();
        wait_idle("t2_idle");
        check("t2_trmts", trmt_cnt - t0, Depth);
        check("t2_seq_done", done_cnt - d0, 1);

        // 5: push into a full FIFO during the LOAD pop cycle
        t0 = trmt_cnt;
        for (int i = 0; i < Depth; i++) push_byte(8'($urandom));
        pulse_start();
        check("t5_load_trmt", bus.trmt, 1);
        b = 8'($urandom);
        bus.push = 1'b1; bus.push_data = b;
        tick();
        bus.push = 1'b0;
        exp_q.push_back(b);
        check("t5_count", bus.count, Depth);
        check("t5_ovf", bus.ovf_err, 0);
        wait_idle("t5_idle");
        check("t5_trmts", trmt_cnt - t0, Depth + 1);

        // 3: UART never answers -> watchdog
        resp_en = 1'b0;
        t0 = trmt_cnt; d0 = done_cnt;
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        pulse_start();
        t_start = cyc;
        n = 0;
        while (!bus.timeout_err && n < 3000) begin
            tick();
            n++;
        end
        check("t3_tmo_latency", cyc - t_start, TmoCyc + 1);
        check("t3_tmo", bus.timeout_err, 1);
        check("t3_empty", bus.empty, 1);
        check("t3_busy", bus.busy, 0);
        tick();
        check("t3_trmts", trmt_cnt - t0, 1);
        check("t3_seq_done", done_cnt - d0, 0);
        exp_q.delete();
        mdl_cnt = 0;
        pulse_clr();
        check("t3_tmo_cleared", bus.timeout_err, 0);
        resp_en = 1'b1;

        // 4: abort in the gap with two bytes queued
        fix_delay = 20;
        t0 = trmt_cnt; d0 = done_cnt;
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        pulse_start();
        repeat (30) tick();
        check("t4_busy_in_gap", bus.busy, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t4_busy", bus.busy, 0);
        check("t4_empty", bus.empty, 1);
        exp_q.delete();
        mdl_cnt = 0;
        repeat (200) tick();
        check("t4_trmts", trmt_cnt - t0, 1);
        check("t4_seq_done", done_cnt - d0, 0);

        // 6: reset mid WAIT_DONE, late tx_done must be ignored
        fix_delay = 100;
        t0 = trmt_cnt; d0 = done_cnt;
        push_byte(8'h47);
        push_byte(8'h53);
        pulse_start();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check_reset_vals("t6");
        rst = 1'b0;
        exp_q.delete();
        mdl_cnt = 0;
        repeat (150) tick();
        check("t6_busy", bus.busy, 0);
        check("t6_trmts", trmt_cnt - t0, 1);
        check("t6_seq_done", done_cnt - d0, 0);

        // randomized sequences
        rand_delay = 1'b1;
        for (int it = 0; it < 20; it++) begin
            d0 = done_cnt;
            k = int'($urandom_range(1, Depth + 2));
            for (int i = 0; i < k; i++) begin
                push_byte(8'($urandom));
                if ($urandom_range(0, 3) == 0) tick();
            end
            check("rnd_count", bus.count, mdl_cnt);
            check("rnd_ovf", bus.ovf_err, mdl_ovf);
            if (mdl_ovf) pulse_clr();
            pulse_start();
            wait_idle("rnd_idle");
            check("rnd_seq_done", done_cnt - d0, 1);
            check("rnd_unsent", exp_q.size(), 0);
            check("rnd_tmo", bus.timeout_err, 0);
            exp_q.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
